memoria_dados_ctrl: RTL and testbench

// Multi-cycle data memory with request/ready handshake; the producer of Exit_DataMem.

---
 rtl/memoria_dados_ctrl.sv | 71 +++++++
 tb/tb_memoria_dados_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/memoria_dados_ctrl.sv
// memoria_dados_ctrl: multi-cycle word data memory with request/ready handshake and pipeline stall
module memoria_dados_ctrl #(
  parameter int unsigned DEPTH_BITS = 8,
  parameter int unsigned LATENCY    = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Address,
  input  logic [31:0] Write_Data,
  output logic [31:0] Exit_DataMem,
  output logic        Ready,
  output logic        Mem_Stall,
  output logic        Misaligned
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t                state_q;
  logic [3:0]            cnt_q;
  logic                  wr_q;
  logic [DEPTH_BITS+1:0] addr_q;
  logic [31:0]           data_q;
  logic [31:0]           mem_q [0:(1<<DEPTH_BITS)-1];
  logic [DEPTH_BITS-1:0] idx;
  logic                  mis;
  logic                  done;
  logic                  req;
  logic                  unused_addr;
  assign unused_addr = ^Address[31:DEPTH_BITS+2];
  assign idx         = addr_q[DEPTH_BITS+1:2];
  assign mis         = |addr_q[1:0];
  assign done        = (state_q == BUSY) && (cnt_q == 4'd0);
  assign req         = MemRead | MemWrite;
  assign Mem_Stall   = (state_q == BUSY) | ((state_q == IDLE) & req);
  // Request FSM: accept in IDLE, count down the latency, complete the access and pulse Ready
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      Ready        <= 1'b0;
      Misaligned   <= 1'b0;
      Exit_DataMem <= '0;
    end else begin
      Ready      <= 1'b0;
      Misaligned <= 1'b0;
      case (state_q)
        IDLE: if (req) begin
          state_q <= BUSY;
          cnt_q   <= 4'(LATENCY - 1);
          wr_q    <= MemWrite;
          addr_q  <= Address[DEPTH_BITS+1:0];
          data_q  <= Write_Data;
        end
        default: if (cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
        else begin
          state_q    <= IDLE;
          Ready      <= 1'b1;
          Misaligned <= mis;
          if (!wr_q) Exit_DataMem <= mis ? 32'd0 : mem_q[idx];
        end
      endcase
    end
  end
  // Storage array: never reset, written only when an aligned write completes
  always_ff @(posedge clock) begin
    if (done && wr_q && !mis && !reset) mem_q[idx] <= data_q;
  end
endmodule

// File: tb/tb_memoria_dados_ctrl.sv
// tb_memoria_dados_ctrl: scoreboard bench for the multi-cycle data memory controller
module tb_memoria_dados_ctrl;
  localparam int LAT = 2;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [31:0] Address = '0;
  logic [31:0] Write_Data = '0;
  logic [31:0] Exit_DataMem;
  logic        Ready;
  logic        Mem_Stall;
  logic        Misaligned;
  logic        sw_rd = 1'b0;
  logic        sw_wr = 1'b0;
  logic [31:0] sw_addr = '0;
  logic [31:0] sw_wdata = '0;
  logic [31:0] sw_exit [1:4];
  logic [4:1]  sw_ready;
  logic [4:1]  sw_stall;
  logic [4:1]  sw_mis;
  int n_checks = 0;
  int n_fail = 0;
  typedef struct {logic [31:0] data; logic mis;} exp_t;
  exp_t        sb[$];
  logic [31:0] mem_m [int];
  logic [31:0] exp_exit = '0;

  always #5 clock = ~clock;

  memoria_dados_ctrl #(.DEPTH_BITS(8), .LATENCY(LAT)) dut (
    .clock(clock), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .Address(Address), .Write_Data(Write_Data), .Exit_DataMem(Exit_DataMem),
    .Ready(Ready), .Mem_Stall(Mem_Stall), .Misaligned(Misaligned));

  for (genvar g = 1; g <= 4; g++) begin : g_sw
    memoria_dados_ctrl #(.DEPTH_BITS(8), .LATENCY(g)) u (
      .clock(clock), .reset(reset), .MemRead(sw_rd), .MemWrite(sw_wr),
      .Address(sw_addr), .Write_Data(sw_wdata), .Exit_DataMem(sw_exit[g]),
      .Ready(sw_ready[g]), .Mem_Stall(sw_stall[g]), .Misaligned(sw_mis[g]));
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // One access through the main instance; caller must be at a negedge
  task automatic access(input logic wr, input logic rd, input logic [31:0] addr,
                        input logic [31:0] wdata, input string name);
    exp_t e;
    int   cyc;
    int   k;
    k = int'(addr[9:2]);
    e.mis = |addr[1:0];
    if (wr) begin
      e.data = exp_exit;
      if (!e.mis) mem_m[k] = wdata;
    end else
      e.data = e.mis ? 32'd0 : (mem_m.exists(k) ? mem_m[k] : 32'd0);
    exp_exit = e.data;
    sb.push_back(e);
    MemWrite = wr; MemRead = rd; Address = addr; Write_Data = wdata;
    #1;
    n_checks++;
    if (Mem_Stall !== 1'b1) begin n_fail++; $display("FAIL %s stall_req got %b want 1", name, Mem_Stall); end
    @(posedge clock);
    #1 MemWrite = 0; MemRead = 0; Address = ~addr; Write_Data = ~wdata;
    cyc = 0;
    do begin
      @(posedge clock);
      cyc++;
      @(negedge clock);
      if (Ready !== 1'b1) begin
        n_checks++;
        if (Mem_Stall !== 1'b1) begin n_fail++; $display("FAIL %s stall_busy got %b want 1", name, Mem_Stall); end
      end
    end while (Ready !== 1'b1 && cyc < 20);
    e = sb.pop_front();
    n_checks += 4;
    if (cyc != LAT) begin n_fail++; $display("FAIL %s ready_offset got %0d want %0d", name, cyc, LAT); end
    if (Exit_DataMem !== e.data) begin n_fail++; $display("FAIL %s exit got %h want %h", name, Exit_DataMem, e.data); end
    if (Misaligned !== e.mis) begin n_fail++; $display("FAIL %s misaligned got %b want %b", name, Misaligned, e.mis); end
    if (Mem_Stall !== 1'b0) begin n_fail++; $display("FAIL %s stall_ready got %b want 0", name, Mem_Stall); end
  endtask

  task automatic test_reset();
    #2 reset = 1;
    #1;
    n_checks += 4;
    if (Exit_DataMem !== 32'd0) begin n_fail++; $display("FAIL reset_exit got %h want 0", Exit_DataMem); end
    if (Ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b want 0", Ready); end
    if (Misaligned !== 1'b0) begin n_fail++; $display("FAIL reset_mis got %b want 0", Misaligned); end
    if (Mem_Stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b want 0", Mem_Stall); end
    repeat (2) @(posedge clock);
    @(negedge clock) reset = 0;
  endtask

  task automatic test_write_read();
    access(1, 0, 32'h10, 32'hDEADBEEF, "wr_10");
    access(0, 1, 32'h10, 32'h0, "rd_10");
  endtask

  task automatic test_back_to_back();
    int last;
    int pulses;
    last = -1;
    pulses = 0;
    MemRead = 1; Address = 32'h10;
    for (int i = 0; i < 12; i++) begin
      @(posedge clock);
      @(negedge clock);
      n_checks++;
      if (Mem_Stall !== 1'b1) begin n_fail++; $display("FAIL b2b_stall cyc %0d got %b want 1", i, Mem_Stall); end
      if (Ready === 1'b1) begin
        n_checks++;
        if (Exit_DataMem !== 32'hDEADBEEF) begin n_fail++; $display("FAIL b2b_exit got %h want deadbeef", Exit_DataMem); end
        if (last >= 0) begin
          n_checks++;
          if (i - last != LAT + 1) begin n_fail++; $display("FAIL b2b_period got %0d want %0d", i - last, LAT + 1); end
        end
        last = i;
        pulses++;
      end
    end
    MemRead = 0;
    n_checks++;
    if (pulses != 4) begin n_fail++; $display("FAIL b2b_pulses got %0d want 4", pulses); end
    exp_exit = 32'hDEADBEEF;
    @(negedge clock);
  endtask

  task automatic test_misaligned();
    access(0, 1, 32'h13, 32'h0, "rd_mis");
    access(1, 0, 32'h20, 32'h1111, "wr_20");
    access(1, 0, 32'h22, 32'h9999, "wr_mis");
    access(0, 1, 32'h20, 32'h0, "rd_20");
  endtask

  task automatic test_alias();
    access(1, 0, 32'h404, 32'h1234, "wr_alias");
    access(0, 1, 32'h4, 32'h0, "rd_alias");
    access(1, 1, 32'h30, 32'hABCD, "wr_both");
    access(0, 1, 32'h30, 32'h0, "rd_both");
  endtask

  task automatic test_reset_busy();
    access(1, 0, 32'h8, 32'hAAAA, "wr_8_old");
    access(0, 1, 32'h8, 32'h0, "rd_8_old");
    MemWrite = 1; Address = 32'h8; Write_Data = 32'h55;
    @(posedge clock);
    #1 MemWrite = 0;
    @(posedge clock);
    #1 reset = 1;
    #1;
    n_checks += 3;
    if (Exit_DataMem !== 32'd0) begin n_fail++; $display("FAIL rstbusy_exit got %h want 0", Exit_DataMem); end
    if (Ready !== 1'b0) begin n_fail++; $display("FAIL rstbusy_ready got %b want 0", Ready); end
    if (Mem_Stall !== 1'b0) begin n_fail++; $display("FAIL rstbusy_stall got %b want 0", Mem_Stall); end
    @(posedge clock);
    @(negedge clock) reset = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      n_checks++;
      if (Ready !== 1'b0) begin n_fail++; $display("FAIL rstbusy_noready cyc %0d got %b want 0", i, Ready); end
    end
    exp_exit = 32'd0;
    access(0, 1, 32'h8, 32'h0, "rd_8_after_rst");
  endtask

  task automatic test_latency_sweep();
    int first [1:4];
    for (int pass = 0; pass < 2; pass++) begin
      sw_wr = (pass == 0); sw_rd = (pass == 1); sw_addr = 32'h40; sw_wdata = 32'hCAFEF00D;
      @(posedge clock);
      #1 sw_wr = 0; sw_rd = 0; sw_addr = 32'h0; sw_wdata = 32'h0;
      for (int g = 1; g <= 4; g++) first[g] = 0;
      for (int c = 1; c <= 10; c++) begin
        @(posedge clock);
        @(negedge clock);
        for (int g = 1; g <= 4; g++)
          if (sw_ready[g] === 1'b1 && first[g] == 0) begin
            first[g] = c;
            if (pass == 1) begin
              n_checks++;
              if (sw_exit[g] !== 32'hCAFEF00D) begin n_fail++; $display("FAIL sweep_exit lat %0d got %h want cafef00d", g, sw_exit[g]); end
            end
          end
      end
      for (int g = 1; g <= 4; g++) begin
        n_checks++;
        if (first[g] != g) begin n_fail++; $display("FAIL sweep_offset pass %0d lat %0d got %0d want %0d", pass, g, first[g], g); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_misaligned();
    test_alias();
    test_reset_busy();
    test_latency_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
